avalon_mm_pio_master: RTL and testbench
=======================================

Name: avalon_mm_pio_master

Overview:
- Avalon-MM initiator that drives the team's PIO-style register slaves (player position, score and similar output/input ports) from local game logic.
- Accepts one command at a time on a valid/ready interface and issues one Avalon read or write.
- Honours waitrequest, captures readdata after a fixed read latency, and returns a one-cycle response pulse.
- Sits between the game-control FSM and the system interconnect.

Parameters:
- ADDR_W, 2, Avalon address width (word address into the slave register map).
- DATA_W, 32, data width of writedata, readdata and the command/response data.
- READ_LATENCY, 0, cycles from read acceptance to valid avm_readdata; legal range 0..3.
- TIMEOUT, 255, maximum cycles of asserted waitrequest before abort; legal range 1..255; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_address  in  ADDR_W  target register address.
- cmd_writedata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_readdata  out  DATA_W  read result; 0 for writes and errors.
- rsp_error  out  1  set with rsp_valid on timeout.
- busy  out  1  transaction in flight (state != IDLE).
- avm_address  out  ADDR_W  Avalon address.
- avm_chipselect  out  1  Avalon chipselect.
- avm_write_n  out  1  Avalon write strobe, active-low.
- avm_read_n  out  1  Avalon read strobe, active-low.
- avm_writedata  out  DATA_W  Avalon write data.
- avm_readdata  in  DATA_W  Avalon read data.
- avm_waitrequest  in  1  slave stall; tie 0 for PIO slaves without it.

Behaviour:
- Reset (synchronous, active-high) values:
  - avm_chipselect=0, avm_write_n=1, avm_read_n=1, avm_address=0, avm_writedata=0.
  - rsp_valid=0, rsp_readdata=0, rsp_error=0, busy=0, state=IDLE.
  - cmd_ready=0 while reset=1.
- All Avalon outputs and all rsp_* outputs are registered. cmd_ready = (state==IDLE) && !reset.
- FSM states: IDLE, REQ, RDWAIT, RSP.
- IDLE:
  - cmd_valid && cmd_ready handshake at edge N latches write/address/data.
  - Next state REQ. At N+1: chipselect=1; write_n=0 (write) or read_n=0 (read); address and writedata valid.
- REQ, waitrequest=1:
  - Hold all bus signals stable; increment wait counter.
  - If the counter reaches TIMEOUT (TIMEOUT != 0): deassert the bus at the next edge, go to RSP with rsp_error=1 and rsp_readdata=0.
- REQ, waitrequest=0: the transfer is accepted at this edge and the bus is deasserted at the next edge.
  - Write: go to RSP, rsp_error=0, rsp_readdata=0.
  - Read with READ_LATENCY=0: capture avm_readdata at this edge; go to RSP.
  - Read with READ_LATENCY=L>0: go to RDWAIT; capture avm_readdata exactly L cycles after the acceptance edge; go to RSP.
- RSP:
  - rsp_valid=1 for exactly one cycle; no response backpressure.
  - Next state IDLE; rsp_readdata and rsp_error hold their values until the next response.
- Latency, write with no stall: handshake edge N, bus active cycle N+1, rsp_valid cycle N+2, cmd_ready high again cycle N+3.
- Latency, read: add READ_LATENCY cycles to the write figures.
- cmd_valid while busy is ignored and not latched. Command fields need only be stable on the handshake edge.
- Reset asserted in any state: abort with no response; bus deasserted at that edge; wait and latency counters cleared.
- The wait counter is 8-bit and saturates; it resets to 0 on every new command.

Decomposition:
- Shared package (avalon_pio_pkg):
  - state enum {IDLE, REQ, RDWAIT, RSP};
  - constants for max READ_LATENCY (3) and timeout counter width (8);
  - PIO register offset constants (DATA=0, DIRECTION=1, IRQMASK=2, EDGECAPTURE=3).
- No sub-module; the wait and latency counters stay inline.

Test Plan:
- Write, no stall: cmd write addr 0 data 0x000000A5 → avm_write_n=0 and chipselect=1 for exactly 1 cycle; slave out_port=0xA5; rsp_valid 2 cycles after handshake, rsp_error=0.
- Read, READ_LATENCY=0: slave holds 0x3C at addr 0 → rsp_readdata=0x0000003C. Read addr 1 → rsp_readdata=0.
- Waitrequest stall: hold waitrequest=1 for 5 cycles on a write → bus signals stable across all 5 cycles; rsp_valid 7 cycles after handshake.
- Timeout, TIMEOUT=4: waitrequest stuck at 1 → bus deasserted after 4 stall cycles; rsp_valid=1, rsp_error=1, rsp_readdata=0; next command accepted normally.
- Read, READ_LATENCY=2: the bench drives 0xDEADBEEF only on the 2nd cycle after acceptance → rsp_readdata=0xDEADBEEF; cmd_valid pulses while busy are ignored.
- Reset mid-REQ (waitrequest=1): reset for 1 cycle → at that edge chipselect=0, write_n=1, read_n=1; no rsp_valid; cmd_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/avalon_pio_pkg.sv
// Shared definitions for the Avalon-MM PIO initiator.
//   state_t            : transaction FSM states
//   MAX_READ_LATENCY   : largest supported slave read latency
//   TIMEOUT_CNT_W      : width of the waitrequest stall counter
//   PIO_*              : word offsets of the standard PIO slave registers
package avalon_pio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    RDWAIT = 2'd2,
    RSP    = 2'd3
  } state_t;

  localparam int MAX_READ_LATENCY = 3;
  localparam int TIMEOUT_CNT_W    = 8;

  localparam logic [1:0] PIO_DATA        = 2'd0;
  localparam logic [1:0] PIO_DIRECTION   = 2'd1;
  localparam logic [1:0] PIO_IRQMASK     = 2'd2;
  localparam logic [1:0] PIO_EDGECAPTURE = 2'd3;

endpackage

// File: rtl/avalon_mm_pio_master.sv
// Avalon-MM initiator for PIO-style register slaves.
// Takes one command at a time (valid/ready), issues a single Avalon read or
// write, honours waitrequest with an optional stall timeout, captures read data
// after a fixed read latency and returns a one-cycle response strobe.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   cmd_valid/ready/write/address/writedata : command channel
//   rsp_valid/readdata/error    : response strobe and payload
//   busy                        : transaction in flight
//   avm_*                       : Avalon-MM master interface (active-low strobes)
module avalon_mm_pio_master
  import avalon_pio_pkg::*;
#(
  parameter int ADDR_W       = 2,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 0,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_writedata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_readdata,
  output logic              rsp_error,
  output logic              busy,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic              avm_read_n,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest
);

  localparam int LAT_W = $clog2(MAX_READ_LATENCY + 1);
  localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_V = TIMEOUT_CNT_W'(TIMEOUT);
  localparam logic [TIMEOUT_CNT_W-1:0] CNT_ONE   = TIMEOUT_CNT_W'(1);
  localparam logic [LAT_W-1:0]         RL_V      = LAT_W'(READ_LATENCY);
  localparam logic [LAT_W-1:0]         LAT_ONE   = LAT_W'(1);

  state_t                   state;
  logic [TIMEOUT_CNT_W-1:0] wait_cnt;
  logic [TIMEOUT_CNT_W-1:0] wait_next;
  logic [LAT_W-1:0]         lat_cnt;

  // Saturating increment so a disabled timeout never wraps the counter.
  assign wait_next = (wait_cnt == '1) ? wait_cnt : wait_cnt + CNT_ONE;

  assign cmd_ready = (state == IDLE) && !reset;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_read_n     <= 1'b1;
      avm_address    <= '0;
      avm_writedata  <= '0;
      rsp_valid      <= 1'b0;
      rsp_readdata   <= '0;
      rsp_error      <= 1'b0;
      wait_cnt       <= '0;
      lat_cnt        <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state          <= REQ;
            avm_chipselect <= 1'b1;
            avm_write_n    <= !cmd_write;
            avm_read_n     <= cmd_write;
            avm_address    <= cmd_address;
            avm_writedata  <= cmd_writedata;
            wait_cnt       <= '0;
          end
        end
        REQ: begin
          if (avm_waitrequest) begin
            wait_cnt <= wait_next;
            // The stall cycle that brings the count up to TIMEOUT aborts.
            if (TIMEOUT != 0 && wait_next == TIMEOUT_V) begin
              state          <= RSP;
              avm_chipselect <= 1'b0;
              avm_write_n    <= 1'b1;
              avm_read_n     <= 1'b1;
              rsp_valid      <= 1'b1;
              rsp_readdata   <= '0;
              rsp_error      <= 1'b1;
            end
          end else begin
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_read_n     <= 1'b1;
            if (!avm_write_n) begin
              state        <= RSP;
              rsp_valid    <= 1'b1;
              rsp_readdata <= '0;
              rsp_error    <= 1'b0;
            end else if (READ_LATENCY == 0) begin
              state        <= RSP;
              rsp_valid    <= 1'b1;
              rsp_readdata <= avm_readdata;
              rsp_error    <= 1'b0;
            end else begin
              // lat_cnt holds the number of edges since acceptance at the next edge.
              state   <= RDWAIT;
              lat_cnt <= LAT_ONE;
            end
          end
        end
        RDWAIT: begin
          if (lat_cnt == RL_V) begin
            state        <= RSP;
            rsp_valid    <= 1'b1;
            rsp_readdata <= avm_readdata;
            rsp_error    <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt + LAT_ONE;
          end
        end
        RSP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_mm_pio_master.sv
// Self-checking bench: instance 0 uses READ_LATENCY=0/TIMEOUT=255, instance 1
// uses READ_LATENCY=2/TIMEOUT=4. The bench acts as the Avalon slave.
module tb_avalon_mm_pio_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cmd_valid[2];
  logic        cmd_ready[2];
  logic        cmd_write[2];
  logic [1:0]  cmd_address[2];
  logic [31:0] cmd_writedata[2];
  logic        rsp_valid[2];
  logic [31:0] rsp_readdata[2];
  logic        rsp_error[2];
  logic        busy[2];
  logic [1:0]  avm_address[2];
  logic        avm_chipselect[2];
  logic        avm_write_n[2];
  logic        avm_read_n[2];
  logic [31:0] avm_writedata[2];
  logic [31:0] avm_readdata[2];
  logic        avm_waitrequest[2];

  avalon_mm_pio_master #(.ADDR_W(2), .DATA_W(32), .READ_LATENCY(0), .TIMEOUT(255)) dut0 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_write(cmd_write[0]),
    .cmd_address(cmd_address[0]), .cmd_writedata(cmd_writedata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_readdata(rsp_readdata[0]), .rsp_error(rsp_error[0]),
    .busy(busy[0]), .avm_address(avm_address[0]), .avm_chipselect(avm_chipselect[0]),
    .avm_write_n(avm_write_n[0]), .avm_read_n(avm_read_n[0]),
    .avm_writedata(avm_writedata[0]), .avm_readdata(avm_readdata[0]),
    .avm_waitrequest(avm_waitrequest[0])
  );

  avalon_mm_pio_master #(.ADDR_W(2), .DATA_W(32), .READ_LATENCY(2), .TIMEOUT(4)) dut1 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_write(cmd_write[1]),
    .cmd_address(cmd_address[1]), .cmd_writedata(cmd_writedata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_readdata(rsp_readdata[1]), .rsp_error(rsp_error[1]),
    .busy(busy[1]), .avm_address(avm_address[1]), .avm_chipselect(avm_chipselect[1]),
    .avm_write_n(avm_write_n[1]), .avm_read_n(avm_read_n[1]),
    .avm_writedata(avm_writedata[1]), .avm_readdata(avm_readdata[1]),
    .avm_waitrequest(avm_waitrequest[1])
  );

  function automatic int rl_of(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  function automatic int to_of(input int i);
    return (i == 0) ? 255 : 4;
  endfunction

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  typedef struct {
    int          inst;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    int          stalls;
    logic [31:0] sdata;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  // One full command: handshake, slave behaviour, bus/response checks.
  // exp_lat counts cycles from the handshake edge to the rsp_valid cycle.
  task automatic run_txn(input int i, input logic wr, input logic [1:0] addr,
                         input logic [31:0] wdata, input int stalls, input logic [31:0] sdata,
                         input logic [31:0] exp_data, input logic exp_err, input int exp_lat,
                         input string tag);
    int          bus_end;
    int          got_lat;
    logic [31:0] got_data;
    logic        got_err;
    bus_end  = exp_err ? exp_lat - 1 : stalls + 1;
    got_lat  = -1;
    got_data = 'x;
    got_err  = 1'bx;
    @(posedge clk); #1;
    cmd_valid[i] = 1'b1; cmd_write[i] = wr; cmd_address[i] = addr; cmd_writedata[i] = wdata;
    @(posedge clk); #1;
    cmd_valid[i] = 1'b0;
    cmd_write[i] = 1'($urandom); cmd_address[i] = 2'($urandom); cmd_writedata[i] = $urandom;
    for (int j = 1; j <= 64; j++) begin
      avm_waitrequest[i] = (j <= stalls);
      avm_readdata[i] = (!wr && !exp_err && j == stalls + 1 + rl_of(i)) ? sdata : $urandom;
      cmd_valid[i] = (j < exp_lat) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (j - 1 < bus_end) begin
        chk({tag, " cs"}, 32'(avm_chipselect[i]), 32'd1);
        chk({tag, " write_n"}, 32'(avm_write_n[i]), 32'(!wr));
        chk({tag, " read_n"}, 32'(avm_read_n[i]), 32'(wr));
        chk({tag, " addr"}, 32'(avm_address[i]), 32'(addr));
        if (wr) chk({tag, " wdata"}, avm_writedata[i], wdata);
      end
      if (j <= exp_lat) begin
        chk({tag, " busy"}, 32'(busy[i]), 32'd1);
        chk({tag, " cmd_ready_busy"}, 32'(cmd_ready[i]), 32'd0);
      end
      if (rsp_valid[i] === 1'b1) begin
        got_lat  = j;
        got_data = rsp_readdata[i];
        got_err  = rsp_error[i];
        chk({tag, " cs_at_rsp"}, 32'(avm_chipselect[i]), 32'd0);
        chk({tag, " strobes_at_rsp"}, {30'd0, avm_write_n[i], avm_read_n[i]}, 32'd3);
        break;
      end
      @(posedge clk); #1;
    end
    cmd_valid[i] = 1'b0;
    avm_waitrequest[i] = 1'b0;
    chk({tag, " latency"}, 32'(got_lat), 32'(exp_lat));
    chk({tag, " rdata"}, got_data, exp_data);
    chk({tag, " error"}, 32'(got_err), 32'(exp_err));
    @(posedge clk); @(negedge clk);
    chk({tag, " rsp_pulse_end"}, 32'(rsp_valid[i]), 32'd0);
    chk({tag, " ready_again"}, 32'(cmd_ready[i]), 32'd1);
    chk({tag, " rdata_hold"}, rsp_readdata[i], exp_data);
    $display("txn %s inst=%0d wr=%0d addr=%0d stalls=%0d lat=%0d rdata=%h err=%0d",
             tag, i, wr, addr, stalls, got_lat, got_data, got_err);
  endtask

  vec_t        vecs[11];
  logic [31:0] mem[2][4];

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0; cmd_write[i] = 1'b0; cmd_address[i] = '0; cmd_writedata[i] = '0;
      avm_readdata[i] = '0; avm_waitrequest[i] = 1'b0;
      for (int a = 0; a < 4; a++) mem[i][a] = '0;
    end

    // inst, wr, addr, wdata, stalls, slave data, exp data, exp err, exp latency
    vecs[0]  = '{0, 1'b1, 2'd0, 32'h000000A5, 0,  32'h0,        32'h0,        1'b0, 2};
    vecs[1]  = '{0, 1'b0, 2'd0, 32'h0,        0,  32'h0000003C, 32'h0000003C, 1'b0, 2};
    vecs[2]  = '{0, 1'b0, 2'd1, 32'h0,        0,  32'h0,        32'h0,        1'b0, 2};
    vecs[3]  = '{0, 1'b1, 2'd2, 32'h12345678, 5,  32'h0,        32'h0,        1'b0, 7};
    vecs[4]  = '{0, 1'b0, 2'd3, 32'h0,        3,  32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 5};
    vecs[5]  = '{1, 1'b0, 2'd0, 32'h0,        0,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 4};
    vecs[6]  = '{1, 1'b1, 2'd1, 32'h11112222, 10, 32'h0,        32'h0,        1'b1, 5};
    vecs[7]  = '{1, 1'b1, 2'd1, 32'h33334444, 3,  32'h0,        32'h0,        1'b0, 5};
    vecs[8]  = '{1, 1'b0, 2'd2, 32'h0,        4,  32'h00000055, 32'h0,        1'b1, 5};
    vecs[9]  = '{1, 1'b0, 2'd3, 32'h0,        3,  32'h0BADF00D, 32'h0BADF00D, 1'b0, 7};
    vecs[10] = '{1, 1'b0, 2'd3, 32'h0,        0,  32'h87654321, 32'h87654321, 1'b0, 4};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst cs", 32'(avm_chipselect[i]), 32'd0);
      chk("rst write_n", 32'(avm_write_n[i]), 32'd1);
      chk("rst read_n", 32'(avm_read_n[i]), 32'd1);
      chk("rst addr", 32'(avm_address[i]), 32'd0);
      chk("rst wdata", avm_writedata[i], 32'd0);
      chk("rst rsp_valid", 32'(rsp_valid[i]), 32'd0);
      chk("rst rdata", rsp_readdata[i], 32'd0);
      chk("rst error", 32'(rsp_error[i]), 32'd0);
      chk("rst busy", 32'(busy[i]), 32'd0);
      chk("rst cmd_ready", 32'(cmd_ready[i]), 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst ready0", 32'(cmd_ready[0]), 32'd1);
    chk("post_rst ready1", 32'(cmd_ready[1]), 32'd1);

    // Directed vectors.
    for (int v = 0; v < 11; v++) begin
      run_txn(vecs[v].inst, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].stalls,
              vecs[v].sdata, vecs[v].exp_data, vecs[v].exp_err, vecs[v].exp_lat,
              $sformatf("vec%0d", v));
    end

    // Reset while stalled in the request phase: abort with no response.
    @(posedge clk); #1;
    cmd_valid[0] = 1'b1; cmd_write[0] = 1'b1; cmd_address[0] = 2'd2; cmd_writedata[0] = 32'h0000BEEF;
    @(posedge clk); #1;
    cmd_valid[0] = 1'b0;
    avm_waitrequest[0] = 1'b1;
    @(negedge clk);
    chk("rstmid cs_before", 32'(avm_chipselect[0]), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid ready_in_reset", 32'(cmd_ready[0]), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid cs", 32'(avm_chipselect[0]), 32'd0);
    chk("rstmid write_n", 32'(avm_write_n[0]), 32'd1);
    chk("rstmid read_n", 32'(avm_read_n[0]), 32'd1);
    chk("rstmid busy", 32'(busy[0]), 32'd0);
    chk("rstmid ready", 32'(cmd_ready[0]), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("rstmid no_rsp", 32'(rsp_valid[0]), 32'd0);
      @(negedge clk);
    end
    avm_waitrequest[0] = 1'b0;
    $display("txn reset_mid_req inst=0 done");

    // Randomized traffic against a simple slave/response model.
    for (int n = 0; n < 60; n++) begin
      int          i;
      logic        wr;
      logic [1:0]  addr;
      logic [31:0] wdata;
      int          stalls;
      bit          tmo;
      int          lat;
      logic [31:0] exp_data;
      i      = n % 2;
      wr     = 1'($urandom_range(0, 1));
      addr   = 2'($urandom_range(0, 3));
      wdata  = $urandom;
      stalls = $urandom_range(0, 6);
      tmo    = (to_of(i) != 0) && (stalls >= to_of(i));
      lat    = tmo ? to_of(i) + 1 : 2 + stalls + (wr ? 0 : rl_of(i));
      exp_data = (wr || tmo) ? 32'h0 : mem[i][addr];
      run_txn(i, wr, addr, wdata, stalls, mem[i][addr], exp_data, tmo, lat,
              $sformatf("rnd%0d", n));
      if (wr && !tmo) mem[i][addr] = wdata;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
